// File: rtl/ysyx_23060332_wbu_pkg.sv
// Shared widths, grant encoding and write-qualification helper for the
// ysyx_23060332 write-back unit.
package ysyx_23060332_wbu_pkg;

   localparam int WBU_XLEN       = 32;
   localparam int WBU_NREG       = 32;
   localparam int WBU_AW         = 5;
   localparam int WBU_STARVE_MAX = 3;

   typedef enum logic [1:0] {
      GNT_NONE = 2'b00,
      GNT_EXU  = 2'b01,
      GNT_LSU  = 2'b10
   } gnt_e;

   // x0 is hardwired to zero, so a result aimed at it never becomes a real write
   function automatic logic wb_is_write(input logic wen, input logic [WBU_AW-1:0] rd);
      return wen && (rd != {WBU_AW{1'b0}});
   endfunction

endpackage

// File: rtl/ysyx_23060332_wbu_sb.sv
// Per-register busy scoreboard: set on issue, cleared when the write is
// registered, with set taking precedence on a same-index collision.
module ysyx_23060332_wbu_sb
   import ysyx_23060332_wbu_pkg::*;
#(
   parameter int NREG = WBU_NREG,
   parameter int AW   = WBU_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_set_en,
   input  logic [AW-1:0] i_set_idx,
   input  logic          i_clr_en,
   input  logic [AW-1:0] i_clr_idx,
   input  logic [AW-1:0] i_rs1,
   input  logic [AW-1:0] i_rs2,
   output logic          o_rs1_busy,
   output logic          o_rs2_busy
);

   logic [NREG-1:0] r_busy;
   logic [NREG-1:0] w_set_mask;
   logic [NREG-1:0] w_clr_mask;
   logic [NREG-1:0] w_busy_nxt;

   // Decode set/clear requests into one-hot masks; a newer producer beats the retiring one
   always_comb begin
      w_set_mask = '0;
      w_clr_mask = '0;
      for (int i = 0; i < NREG; i++) begin
         if (i_set_en && (i_set_idx == AW'(i))) begin
            w_set_mask[i] = 1'b1;
         end else begin
            w_set_mask[i] = 1'b0;
         end
         if (i_clr_en && (i_clr_idx == AW'(i))) begin
            w_clr_mask[i] = 1'b1;
         end else begin
            w_clr_mask[i] = 1'b0;
         end
      end
      w_busy_nxt    = (r_busy & ~w_clr_mask) | w_set_mask;
      w_busy_nxt[0] = 1'b0;
   end

   // Busy state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   assign o_rs1_busy = r_busy[i_rs1];
   assign o_rs2_busy = r_busy[i_rs2];

endmodule

// File: rtl/ysyx_23060332_wbu.sv
// Write-back unit: arbitrates EXU/LSU results onto the single GPR write port,
// registers the write, counts commits and exposes busy/forward status to IDU.
module ysyx_23060332_wbu
   import ysyx_23060332_wbu_pkg::*;
#(
   parameter int XLEN       = WBU_XLEN,
   parameter int NREG       = WBU_NREG,
   parameter int AW         = WBU_AW,
   parameter int STARVE_MAX = WBU_STARVE_MAX
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_iss_valid,
   input  logic            i_iss_wen,
   input  logic [AW-1:0]   i_iss_rd,
   input  logic            i_exu_valid,
   output logic            o_exu_ready,
   input  logic            i_exu_wen,
   input  logic [AW-1:0]   i_exu_rd,
   input  logic [XLEN-1:0] i_exu_data,
   input  logic            i_lsu_valid,
   output logic            o_lsu_ready,
   input  logic            i_lsu_wen,
   input  logic [AW-1:0]   i_lsu_rd,
   input  logic [XLEN-1:0] i_lsu_data,
   input  logic [AW-1:0]   i_idu_rs1,
   input  logic [AW-1:0]   i_idu_rs2,
   output logic            o_rs1_busy,
   output logic            o_rs2_busy,
   output logic            o_rs1_fwd,
   output logic            o_rs2_fwd,
   output logic [XLEN-1:0] o_fwd_data,
   output logic [AW-1:0]   o_reg_waddr,
   output logic [XLEN-1:0] o_reg_wdata,
   output logic            o_reg_wen,
   output logic [31:0]     o_commit_cnt
);

   localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   gnt_e            w_gnt;
   logic            w_starved;
   logic            w_acc;
   logic            w_acc_wen;
   logic [AW-1:0]   w_acc_rd;
   logic [XLEN-1:0] w_acc_data;
   logic            w_wr;
   logic            w_iss_set;

   logic [SW-1:0]   r_starve;
   logic            r_wen;
   logic [AW-1:0]   r_waddr;
   logic [XLEN-1:0] r_wdata;
   logic [31:0]     r_commit_cnt;

   assign w_starved = (r_starve == STARVE_LIM);

   // LSU normally owns the port; a starved EXU takes it for one cycle
   always_comb begin
      w_gnt = GNT_NONE;
      if (rst) begin
         w_gnt = GNT_NONE;
      end else if (i_exu_valid && (w_starved || !i_lsu_valid)) begin
         w_gnt = GNT_EXU;
      end else if (i_lsu_valid) begin
         w_gnt = GNT_LSU;
      end else begin
         w_gnt = GNT_NONE;
      end
   end

   assign o_exu_ready = (w_gnt == GNT_EXU);
   assign o_lsu_ready = (w_gnt == GNT_LSU);

   // Select the payload of whichever source won the grant
   always_comb begin
      w_acc      = 1'b0;
      w_acc_wen  = 1'b0;
      w_acc_rd   = '0;
      w_acc_data = '0;
      case (w_gnt)
         GNT_EXU: begin
            w_acc      = 1'b1;
            w_acc_wen  = i_exu_wen;
            w_acc_rd   = i_exu_rd;
            w_acc_data = i_exu_data;
         end
         GNT_LSU: begin
            w_acc      = 1'b1;
            w_acc_wen  = i_lsu_wen;
            w_acc_rd   = i_lsu_rd;
            w_acc_data = i_lsu_data;
         end
         default: begin
            w_acc      = 1'b0;
            w_acc_wen  = 1'b0;
            w_acc_rd   = '0;
            w_acc_data = '0;
         end
      endcase
   end

   assign w_wr      = w_acc && wb_is_write(w_acc_wen, w_acc_rd);
   assign w_iss_set = i_iss_valid && wb_is_write(i_iss_wen, i_iss_rd);

   // Consecutive EXU losses; an idle or accepted EXU starts the count over
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_starve <= '0;
      end else if (i_exu_valid && !o_exu_ready) begin
         if (!w_starved) begin
            r_starve <= r_starve + SW'(1);
         end else begin
            r_starve <= r_starve;
         end
      end else begin
         r_starve <= '0;
      end
   end

   // Registered write port and commit counter; address and data hold when idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wen        <= 1'b0;
         r_waddr      <= '0;
         r_wdata      <= '0;
         r_commit_cnt <= 32'h0000_0000;
      end else if (w_acc) begin
         r_wen        <= w_wr;
         r_waddr      <= w_acc_rd;
         r_wdata      <= w_acc_data;
         r_commit_cnt <= r_commit_cnt + 32'd1;
      end else begin
         r_wen        <= 1'b0;
      end
   end

   ysyx_23060332_wbu_sb #(
      .NREG (NREG),
      .AW   (AW)
   ) u_sb (
      .clk        (clk),
      .rst        (rst),
      .i_set_en   (w_iss_set),
      .i_set_idx  (i_iss_rd),
      .i_clr_en   (w_wr),
      .i_clr_idx  (w_acc_rd),
      .i_rs1      (i_idu_rs1),
      .i_rs2      (i_idu_rs2),
      .o_rs1_busy (o_rs1_busy),
      .o_rs2_busy (o_rs2_busy)
   );

   // Busy drops at the accept edge, one cycle before the register file holds the value
   assign o_rs1_fwd    = r_wen && (r_waddr == i_idu_rs1) && (i_idu_rs1 != '0);
   assign o_rs2_fwd    = r_wen && (r_waddr == i_idu_rs2) && (i_idu_rs2 != '0);
   assign o_fwd_data   = r_wdata;
   assign o_reg_wen    = r_wen;
   assign o_reg_waddr  = r_waddr;
   assign o_reg_wdata  = r_wdata;
   assign o_commit_cnt = r_commit_cnt;

endmodule

// File: doc/ysyx_23060332_wbu.md
Name: ysyx_23060332_wbu

Overview:
Write-back unit: the writer side of the GPR file's single write port. Accepts results from EXU and LSU over valid/ready handshakes and arbitrates between them. Drives a registered write (waddr/wdata/reg_wen) into the register file. Keeps a per-register busy scoreboard and a forwarding path so IDU can stall or bypass read-after-write hazards.

Parameters:
XLEN, 32, data width
NREG, 32, number of architectural registers
AW, 5, register address width (log2 NREG)
STARVE_MAX, 3, consecutive EXU losses before EXU is forced to win

Ports:
clk  in  1  clock
rst  in  1  reset
iss_valid  in  1  IDU issues an instruction this cycle
iss_wen  in  1  issued instruction writes rd
iss_rd  in  AW  destination of issued instruction
exu_valid  in  1  EXU result valid
exu_ready  out  1  WBU accepts EXU result
exu_wen  in  1  EXU result writes rd
exu_rd  in  AW  EXU destination
exu_data  in  XLEN  EXU result
lsu_valid / lsu_ready / lsu_wen / lsu_rd / lsu_data  same as exu_*, for the LSU
idu_rs1, idu_rs2  in  AW  IDU source indices
rs1_busy, rs2_busy  out  1  source has an outstanding writer not yet presented
rs1_fwd, rs2_fwd  out  1  source equals the write on the reg_* outputs this cycle
fwd_data  out  XLEN  equals reg_wdata
reg_waddr  out  AW  to register file waddr
reg_wdata  out  XLEN  to register file wdata
reg_wen  out  1  to register file reg_wen
commit_cnt  out  32  count of accepted results, wraps at 2^32

Behaviour:
- Reset: asynchronous, active-high. Clears all state immediately, independent of clk: reg_wen=0, reg_waddr=0, reg_wdata=0, commit_cnt=0, scoreboard all 0, starve_cnt=0. The ready outputs are low while rst is high. Any in-flight result is dropped, with no write.
- Arbitration (combinational grant): LSU has priority. If starve_cnt==STARVE_MAX and exu_valid, EXU wins instead. At most one ready is high per cycle. A loser's ready is low, and it must hold its payload (valid/ready protocol).
- starve_cnt: increments when exu_valid && !exu_ready, saturating at STARVE_MAX. Clears on an EXU accept or when !exu_valid.
- Accept (valid&&ready): at the next edge, reg_waddr<=rd, reg_wdata<=data, reg_wen<=wen&&(rd!=0), commit_cnt++. With no accept, reg_wen<=0 and the address and data hold. Latency: 1 cycle from accept to the reg_* outputs; the register file updates at the following edge.
- Accepts with wen=0 or rd=0 still handshake and count, but produce no write.
- Scoreboard busy[NREG]: set on iss_valid&&iss_wen&&iss_rd!=0. Cleared at the edge that registers an accepted write to that rd. If a set and a clear hit the same index on the same edge, set wins (a newer producer exists). busy[0] is always 0.
- rsN_busy = busy[idu_rsN]. rsN_fwd = reg_wen && reg_waddr==idu_rsN && idu_rsN!=0. The fwd path is needed because busy has already dropped while the register file has not yet been written.
- Single-writer rule per rd: IDU must not reissue to a busy rd. This is not checked; the scoreboard holds one bit only.

Decomposition:
- Shared define file: XLEN, AW, NREG macros (RegAddrBus/RegDataBus style) and the STARVE_MAX default.
- One sub-module: ysyx_23060332_wbu_sb. It holds the scoreboard set/clear logic and the two busy lookups. Arbitration, the output register and commit_cnt stay in the top.

Test Plan:
- Reset mid-write: accept EXU rd=5, data 0xDEADBEEF, then assert rst between edges -> reg_wen drops to 0 immediately, busy all 0, commit_cnt=0.
- Single EXU write: iss rd=3, then EXU accept rd=3, data 0x12 -> next cycle reg_wen=1, waddr=3, wdata=0x12, rs1_busy(3)=0, rs1_fwd=1, fwd_data=0x12.
- Contention: LSU and EXU both valid for 5 cycles -> LSU wins cycles 0-2, EXU wins the 4th cycle (starve_cnt=3), then LSU again. commit_cnt=5.
- x0 and wen=0: EXU rd=0, data 0xFF, and LSU wen=0 rd=7 -> both accepted, reg_wen stays 0, commit_cnt=2, busy[0]=0.
- Set/clear collision: iss rd=9 on the same edge that registers the write of rd=9 -> busy[9]=1 afterwards, reg_wen=1, waddr=9.
- Counter wrap: preload commit_cnt to 0xFFFFFFFF via force, then one accept -> 0x00000000.
